// File: rtl/mac_reduce_pkg.sv
// Purpose : shared constants and FSM state type for the mac_reduce32 reduction stage.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package mac_reduce_pkg;

    localparam int NUM_LANES = 32;
    localparam int PROD_W    = 32;
    localparam int TREE_LVLS = 5;
    localparam int SUM_W     = PROD_W + TREE_LVLS;   // 37: one carry bit per tree level

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

endpackage

// File: rtl/adder_tree32.sv
// Purpose : registered 5-level adder tree reducing 32 unsigned products to one 37-bit sum.
// Latency : fixed 5 cycles, {valid,last} sidebands travel with the data.
// Backpressure: none; every cycle advances, invalid beats flow through and are ignored downstream.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset (clears sideband valids only)
//   in_valid, in_last   sidebands coincident with mul_p
//   mul_p               32 lanes x 32-bit products, lane i at [32i+31:32i]
//   out_valid, out_last sidebands aligned with out_sum
//   out_sum             37-bit lane total
//   any_valid           some sideband valid bit inside the tree is set
module adder_tree32
    import mac_reduce_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          in_valid,
    input  logic                          in_last,
    input  logic [NUM_LANES*PROD_W-1:0]   mul_p,
    output logic                          out_valid,
    output logic                          out_last,
    output logic [SUM_W-1:0]              out_sum,
    output logic                          any_valid
);

    // Nodes are a heap: node[0] is the root, node[i] has children 2i+1/2i+2.
    // The 16 bottom nodes (INNER..NODES-1) add pairs of leaves. Every node is
    // stored at full SUM_W; upper bits of shallow levels are constant zero.
    localparam int NODES = NUM_LANES - 1;   // 31
    localparam int INNER = NUM_LANES/2 - 1; // 15 nodes fed by other nodes

    logic [SUM_W-1:0]     leaf [NUM_LANES];
    logic [SUM_W-1:0]     node [NODES];
    logic [TREE_LVLS-1:0] vld_sr;
    logic [TREE_LVLS-1:0] lst_sr;

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            leaf[i] = SUM_W'(mul_p[i*PROD_W +: PROD_W]);
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < INNER; i++) begin
            node[i] <= node[2*i+1] + node[2*i+2];
        end
        for (int i = INNER; i < NODES; i++) begin
            node[i] <= leaf[2*(i-INNER)] + leaf[2*(i-INNER)+1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_sr <= '0;
            lst_sr <= '0;
        end else begin
            vld_sr <= {vld_sr[TREE_LVLS-2:0], in_valid};
            lst_sr <= {lst_sr[TREE_LVLS-2:0], in_last};
        end
    end

    assign out_sum   = node[0];
    assign out_valid = vld_sr[TREE_LVLS-1];
    assign out_last  = lst_sr[TREE_LVLS-1];
    assign any_valid = |vld_sr;

endmodule

// File: rtl/mac_reduce32.sv
// Purpose : align operand valid/last to the multiplier, reduce 32 products, accumulate per frame, emit one sum per frame.
// Latency : in_valid&in_last at edge k -> out_valid in the cycle after edge k+MUL_LAT+6.
// Backpressure: none; one beat per cycle accepted, out_valid must be consumed unconditionally.
//
// Ports: clk_i/rst_i (sync active-high), in_valid/in_last (operand issue), mul_p (32x32 products,
//        MUL_LAT cycles after issue), out_valid/out_data/out_beats/out_ovf (frame result), busy.
// Optional build macro MAC_REDUCE_SAT_EN: saturate the accumulator and report a sticky
// per-frame overflow on out_ovf; without it the accumulator wraps and out_ovf is 0.
module mac_reduce32
    import mac_reduce_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int ACC_W   = 48,
    parameter int BEAT_W  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          in_valid,
    input  logic                          in_last,
    input  logic [NUM_LANES*PROD_W-1:0]   mul_p,
    output logic                          out_valid,
    output logic [ACC_W-1:0]              out_data,
    output logic [BEAT_W-1:0]             out_beats,
    output logic                          out_ovf,
    output logic                          busy
);

    logic v0, l0, align_any;
    logic vt, lt, tree_any;
    logic [SUM_W-1:0] tree_sum;

    // Align: delay {valid,last} so they meet the products of the same beat.
    generate
        if (MUL_LAT == 0) begin : g_no_align
            assign v0        = in_valid;
            assign l0        = in_valid & in_last;
            assign align_any = 1'b0;
        end else begin : g_align
            logic [MUL_LAT-1:0] vld_sr;
            logic [MUL_LAT-1:0] lst_sr;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    vld_sr <= '0;
                    lst_sr <= '0;
                end else begin
                    // Truncating the concat drops the oldest bit, works for MUL_LAT==1 too.
                    vld_sr <= MUL_LAT'({vld_sr, in_valid});
                    lst_sr <= MUL_LAT'({lst_sr, in_valid & in_last});
                end
            end
            assign v0        = vld_sr[MUL_LAT-1];
            assign l0        = lst_sr[MUL_LAT-1];
            assign align_any = |vld_sr;
        end
    endgenerate

    adder_tree32 u_tree (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (v0),
        .in_last   (l0),
        .mul_p     (mul_p),
        .out_valid (vt),
        .out_last  (lt),
        .out_sum   (tree_sum),
        .any_valid (tree_any)
    );

    acc_state_t       state;
    logic [ACC_W-1:0] acc;
    logic [BEAT_W-1:0] cnt;
    logic [ACC_W-1:0] sum_ext;
    logic [ACC_W-1:0] acc_next;
    logic [BEAT_W-1:0] cnt_inc;
    logic             emit_pend;   // closing beat was accumulated last edge

    assign sum_ext = ACC_W'(tree_sum);
    assign cnt_inc = (cnt == '1) ? cnt : cnt + BEAT_W'(1);

`ifdef MAC_REDUCE_SAT_EN
    logic [ACC_W:0] acc_wide;
    logic           acc_carry;
    logic           ovf;
    assign acc_wide  = {1'b0, acc} + {1'b0, sum_ext};
    assign acc_carry = acc_wide[ACC_W];
    assign acc_next  = acc_carry ? '1 : acc_wide[ACC_W-1:0];
`else
    assign acc_next  = acc + sum_ext;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            emit_pend <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_beats <= '0;
`ifdef MAC_REDUCE_SAT_EN
            ovf       <= 1'b0;
            out_ovf   <= 1'b0;
`endif
        end else begin
            // Emit register samples the finished acc while the accumulator may
            // already be loading the first beat of the next frame.
            emit_pend <= vt & lt;
            out_valid <= emit_pend;
            if (emit_pend) begin
                out_data  <= acc;
                out_beats <= cnt;
`ifdef MAC_REDUCE_SAT_EN
                out_ovf   <= ovf;
`endif
            end
            if (vt) begin
                case (state)
                    IDLE: begin
                        acc <= sum_ext;
                        cnt <= BEAT_W'(1);
`ifdef MAC_REDUCE_SAT_EN
                        ovf <= 1'b0;
`endif
                    end
                    default: begin
                        acc <= acc_next;
                        cnt <= cnt_inc;
`ifdef MAC_REDUCE_SAT_EN
                        ovf <= ovf | acc_carry;
`endif
                    end
                endcase
                state <= lt ? IDLE : ACCUM;
            end
        end
    end

`ifndef MAC_REDUCE_SAT_EN
    assign out_ovf = 1'b0;
`endif

    assign busy = (state == ACCUM) | align_any | tree_any;

endmodule

// File: tb/tb_mac_reduce32.sv
// Purpose : self-checking bench for mac_reduce32 (ACC_W=48 and ACC_W=37 instances, shared stimulus).
// Latency : checks out_valid lands MUL_LAT+6 cycles after the closing beat is issued.
// Backpressure: none; outputs are scoreboarded every cycle they are valid.
module tb_mac_reduce32;
    import mac_reduce_pkg::*;

    localparam int ML = 2;
    localparam int PW = NUM_LANES*PROD_W;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last  = 1'b0;
    logic [PW-1:0] prod_in  = '0;
    logic [PW-1:0] pd [ML];
    logic [PW-1:0] mul_p;

    logic          va, vb, ovfa, ovfb, busya, busyb;
    logic [47:0]   oda;
    logic [36:0]   odb;
    logic [15:0]   oba, obb;

    always #5 clk_i = ~clk_i;

    // Stand-in for the multiplier array: products appear ML cycles after issue.
    always @(posedge clk_i) begin
        pd[0] <= prod_in;
        for (int i = 1; i < ML; i++) pd[i] <= pd[i-1];
    end
    assign mul_p = pd[ML-1];

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    mac_reduce32 #(.MUL_LAT(ML), .ACC_W(48), .BEAT_W(16)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid(in_valid), .in_last(in_last), .mul_p(mul_p),
        .out_valid(va), .out_data(oda), .out_beats(oba), .out_ovf(ovfa), .busy(busya));

    mac_reduce32 #(.MUL_LAT(ML), .ACC_W(37), .BEAT_W(16)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid(in_valid), .in_last(in_last), .mul_p(mul_p),
        .out_valid(vb), .out_data(odb), .out_beats(obb), .out_ovf(ovfb), .busy(busyb));

    typedef struct {
        longint unsigned da;
        longint unsigned db;
        int              beats;
        bit              oa;
        bit              ob;
        int              ecyc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    longint unsigned m_acc_a, m_acc_b;
    bit              m_ovf_a, m_ovf_b;
    int              m_cnt;
    bit              m_first = 1'b1;

    task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_add(inout longint unsigned acc, inout bit ovf,
                             input longint unsigned add, input int w, input bit first);
        longint unsigned mask, s;
        mask = (64'd1 << w) - 64'd1;
        s    = (first ? 64'd0 : acc) + add;
        if (first) ovf = 1'b0;
`ifdef MAC_REDUCE_SAT_EN
        if (s > mask) begin
            s   = mask;
            ovf = 1'b1;
        end
`else
        s   = s & mask;
        ovf = 1'b0;
`endif
        acc = s;
    endtask

    function automatic logic [PW-1:0] fill(input logic [31:0] v);
        logic [PW-1:0] p;
        for (int i = 0; i < NUM_LANES; i++) p[i*PROD_W +: PROD_W] = v;
        return p;
    endfunction

    function automatic logic [PW-1:0] ramp();
        logic [PW-1:0] p;
        for (int i = 0; i < NUM_LANES; i++) p[i*PROD_W +: PROD_W] = 32'(i);
        return p;
    endfunction

    function automatic logic [PW-1:0] lane0(input logic [31:0] v);
        logic [PW-1:0] p;
        p = '0;
        p[PROD_W-1:0] = v;
        return p;
    endfunction

    task automatic beat(input logic [PW-1:0] p, input bit last);
        longint unsigned s;
        exp_t e;
        s = 0;
        @(posedge clk_i); #1;
        in_valid = 1'b1;
        in_last  = last;
        prod_in  = p;
        for (int i = 0; i < NUM_LANES; i++) s += 64'(p[i*PROD_W +: PROD_W]);
        model_add(m_acc_a, m_ovf_a, s, 48, m_first);
        model_add(m_acc_b, m_ovf_b, s, 37, m_first);
        m_cnt   = m_first ? 1 : m_cnt + 1;
        m_first = last;
        if (last) begin
            e.da = m_acc_a; e.db = m_acc_b; e.beats = m_cnt;
            e.oa = m_ovf_a; e.ob = m_ovf_b;
            e.ecyc = cyc + 1 + ML + 6;
            q.push_back(e);
        end
    endtask

    // Idle cycles; optionally with a stray in_last and garbage products.
    task automatic idle(input int n, input bit stray_last);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
            in_valid = 1'b0;
            in_last  = stray_last;
            prod_in  = fill(32'(i * 7 + 3));
        end
        @(posedge clk_i); #1;
        in_last = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() > 0; i++) @(negedge clk_i);
        check_eq("drain_empty", 64'(q.size()), 0);
    endtask

    always @(negedge clk_i) begin
        if (va || vb) begin
            exp_t e;
            check_eq("vld_match", 64'(vb), 64'(va));
            check_eq("q_nonempty", 64'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check_eq("data_a",  64'(oda),  e.da);
                check_eq("data_b",  64'(odb),  e.db);
                check_eq("beats_a", 64'(oba),  64'(e.beats));
                check_eq("beats_b", 64'(obb),  64'(e.beats));
                check_eq("ovf_a",   64'(ovfa), 64'(e.oa));
                check_eq("ovf_b",   64'(ovfb), 64'(e.ob));
                check_eq("latency", 64'(cyc),  64'(e.ecyc));
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_valid", 64'(va), 0);
        check_eq("rst_data",  64'(oda), 0);
        check_eq("rst_beats", 64'(oba), 0);
        check_eq("rst_ovf",   64'(ovfa), 0);
        check_eq("rst_busy",  64'(busya | busyb), 0);
        rst_i = 1'b0;

        // single-beat frame, all lanes 1 -> 32
        beat(fill(32'd1), 1'b1);
        idle(2, 1'b0);
        drain();

        // 4-beat frame, lane i = i -> 4*496
        beat(ramp(), 1'b0);
        beat(ramp(), 1'b0);
        check_eq("busy_mid", 64'(busya), 1);
        beat(ramp(), 1'b0);
        beat(ramp(), 1'b1);
        idle(1, 1'b0);
        drain();
        check_eq("busy_after", 64'(busya), 0);

        // back-to-back single-beat frames
        beat(lane0(32'd100), 1'b1);
        beat(lane0(32'd200), 1'b1);
        beat(lane0(32'd300), 1'b1);
        idle(1, 1'b0);
        drain();

        // 3 full-scale beats with 2-cycle bubbles carrying a stray in_last
        beat(fill(32'hFFFF_FFFF), 1'b0);
        idle(2, 1'b1);
        beat(fill(32'hFFFF_FFFF), 1'b0);
        idle(2, 1'b1);
        beat(fill(32'hFFFF_FFFF), 1'b1);
        idle(1, 1'b0);
        drain();

        // two full-scale beats: wraps/saturates the 37-bit instance
        beat(fill(32'hFFFF_FFFF), 1'b0);
        beat(fill(32'hFFFF_FFFF), 1'b1);
        beat(lane0(32'd5), 1'b1);   // next frame must clear the sticky flag
        idle(1, 1'b0);
        drain();

        // random short frames
        for (int f = 0; f < 6; f++) begin
            int len;
            len = int'($urandom_range(1, 3));
            for (int b = 0; b < len; b++) begin
                logic [PW-1:0] p;
                for (int i = 0; i < NUM_LANES; i++) p[i*PROD_W +: PROD_W] = $urandom;
                beat(p, b == len - 1);
                if ($urandom_range(0, 1) == 1) idle(1, 1'b0);
            end
        end
        idle(1, 1'b0);
        drain();

        // reset midway through a 5-beat frame
        beat(fill(32'd9), 1'b0);
        beat(fill(32'd9), 1'b0);
        beat(fill(32'd9), 1'b0);
        @(posedge clk_i); #1;
        in_valid = 1'b0;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        m_first = 1'b1;
        check_eq("rst_mid_busy", 64'(busya | busyb), 0);
        check_eq("rst_mid_vld", 64'(va), 0);
        beat(fill(32'd7), 1'b1);
        idle(1, 1'b0);
        drain();
        idle(4, 1'b0);
        check_eq("hold_data", 64'(oda), 224);
        check_eq("hold_beats", 64'(oba), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected finish earlier", cyc);
        $fatal(1);
    end

endmodule
